// File: rtl/video_line_buffer5.sv
// Five-row vertical window: four previous lines in read-first RAMs plus the live row.
// Optional macro LB_BORDER_REPLICATE_EN: invalid taps copy the nearest valid lower tap.
module video_line_buffer5 #(
  parameter int unsigned MAX_WIDTH = 1920,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned DATA_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   y_i,
  input  logic                dv_i,
  input  logic                hs_i,
  input  logic                vs_i,
  output logic [5*DATA_W-1:0] taps_o,
  output logic [4:0]          tap_valid_o,
  output logic                dv_o,
  output logic                hs_o,
  output logic                vs_o,
  output logic [ADDR_W-1:0]   col_o,
  output logic [ADDR_W:0]     width_o,
  output logic                ovf_o
);

  localparam logic [ADDR_W:0]   MaxCnt = (ADDR_W+1)'(MAX_WIDTH);
  localparam logic [ADDR_W-1:0] MaxCol = ADDR_W'(MAX_WIDTH - 1);

  // Line bookkeeping
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [1:0]      sel_q, sel_d;
  logic [2:0]      seen_q, seen_d;
  logic [ADDR_W:0] width_q, width_d;
  logic            ovf_q, ovf_d;
  logic            dv_prev_q, vs_prev_q;

  logic              eol, fs, full, we;
  logic [ADDR_W-1:0] addr;
  logic [4:0]        vld_in;

  assign eol  = !dv_i && dv_prev_q;
  assign fs   = vs_i && !vs_prev_q;
  // cnt_q counts accepted pixels; once it reaches MAX_WIDTH the line has overflowed.
  assign full = (cnt_q >= MaxCnt);
  assign we   = dv_i && !full;
  assign addr = full ? MaxCol : cnt_q[ADDR_W-1:0];

  always_comb begin
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    seen_d  = seen_q;
    width_d = width_q;
    ovf_d   = ovf_q;
    if (we) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (dv_i && full) begin
      ovf_d = 1'b1;
    end
    if (eol) begin
      cnt_d   = '0;
      width_d = cnt_q;
      sel_d   = sel_q + 2'd1;
      if (seen_q != 3'd4) begin
        seen_d = seen_q + 3'd1;
      end
    end
    // Frame start wins over end of line for lines_seen; sel still advances.
    if (fs) begin
      seen_d = '0;
      ovf_d  = 1'b0;
    end
  end

  always_comb begin
    vld_in = '0;
    for (int k = 0; k < 5; k++) begin
      vld_in[k] = dv_i && (seen_q >= 3'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      sel_q     <= '0;
      seen_q    <= '0;
      width_q   <= '0;
      ovf_q     <= 1'b0;
      dv_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      seen_q    <= seen_d;
      width_q   <= width_d;
      ovf_q     <= ovf_d;
      dv_prev_q <= dv_i;
      vs_prev_q <= vs_i;
    end
  end

  assign width_o = width_q;
  assign ovf_o   = ovf_q;

  // Line RAMs: read-first, since RAM[sel] is read and overwritten at the same address.
  logic [4*DATA_W-1:0] rd_data;

  for (genvar g = 0; g < 4; g++) begin : g_ram
    logic [DATA_W-1:0] mem [MAX_WIDTH];
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
      rd_q <= mem[addr];
      if (we && (sel_q == 2'(g))) begin
        mem[addr] <= y_i;
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = rd_q;
  end

  // Stage 1: aligned with RAM read data
  logic              dv_s1_q, hs_s1_q, vs_s1_q;
  logic [ADDR_W-1:0] col_s1_q;
  logic [DATA_W-1:0] y_s1_q;
  logic [4:0]        vld_s1_q;
  logic [1:0]        sel_s1_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      dv_s1_q  <= 1'b0;
      hs_s1_q  <= 1'b0;
      vs_s1_q  <= 1'b0;
      col_s1_q <= '0;
      y_s1_q   <= '0;
      vld_s1_q <= '0;
      sel_s1_q <= '0;
    end else begin
      dv_s1_q  <= dv_i;
      hs_s1_q  <= hs_i;
      vs_s1_q  <= vs_i;
      col_s1_q <= dv_i ? addr : '0;
      y_s1_q   <= y_i;
      vld_s1_q <= vld_in;
      sel_s1_q <= sel_q;
    end
  end

  logic [DATA_W-1:0]   tap_raw [5];
  logic [DATA_W-1:0]   fill;
  logic [5*DATA_W-1:0] taps_d;

  always_comb begin
    tap_raw[0] = y_s1_q;
    for (int k = 1; k < 5; k++) begin
      logic [1:0] idx;
      idx        = sel_s1_q - 2'(k);
      tap_raw[k] = rd_data[int'(idx)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    fill   = '0;
    taps_d = '0;
    for (int k = 0; k < 5; k++) begin
      if (vld_s1_q[k]) begin
        fill = tap_raw[k];
      end
`ifndef LB_BORDER_REPLICATE_EN
      else begin
        fill = '0;
      end
`endif
      taps_d[k*DATA_W +: DATA_W] = fill;
    end
  end

  // Stage 2: registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      taps_o      <= '0;
      tap_valid_o <= '0;
      dv_o        <= 1'b0;
      hs_o        <= 1'b0;
      vs_o        <= 1'b0;
      col_o       <= '0;
    end else begin
      taps_o      <= taps_d;
      tap_valid_o <= vld_s1_q;
      dv_o        <= dv_s1_q;
      hs_o        <= hs_s1_q;
      vs_o        <= vs_s1_q;
      col_o       <= col_s1_q;
    end
  end

endmodule

// File: tb/tb_video_line_buffer5.sv
// Scoreboard bench for video_line_buffer5: expectations queued at drive, compared 2 clk later.
module tb_video_line_buffer5;

  localparam int MAXW = 1920;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  y_i = '0;
  logic        dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [39:0] taps_o;
  logic [4:0]  tap_valid_o;
  logic        dv_o, hs_o, vs_o, ovf_o;
  logic [10:0] col_o;
  logic [11:0] width_o;

  always #5 clk = ~clk;

  video_line_buffer5 dut (
    .clk         (clk),
    .rst         (rst),
    .y_i         (y_i),
    .dv_i        (dv_i),
    .hs_i        (hs_i),
    .vs_i        (vs_i),
    .taps_o      (taps_o),
    .tap_valid_o (tap_valid_o),
    .dv_o        (dv_o),
    .hs_o        (hs_o),
    .vs_o        (vs_o),
    .col_o       (col_o),
    .width_o     (width_o),
    .ovf_o       (ovf_o)
  );

  typedef struct {
    logic        dv, hs, vs;
    logic [10:0] col;
    logic [39:0] taps;
    logic [4:0]  vld;
    int          tag;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_err = 0;
  bit armed = 0;

  // Reference state, written from the block's storage and line rules
  logic [7:0] m_mem [4][2048];
  int m_cnt = 0, m_sel = 0, m_seen = 0, m_width = 0;
  bit m_ovf = 0, m_dvp = 0, m_vsp = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle(input logic [7:0] y, input logic dv, input logic hs, input logic vs,
                       input logic rs, input int tag);
    exp_t e, o;
    int addr;
    logic [7:0] fill;
    @(negedge clk);
    if (armed) begin
      check_eq("width", width_o, 64'(m_width));
      check_eq("ovf", ovf_o, 64'(m_ovf));
    end
    if (q.size() >= 2) begin
      o = q.pop_front();
      check_eq("dv", dv_o, o.dv);
      check_eq("hs", hs_o, o.hs);
      check_eq("vs", vs_o, o.vs);
      check_eq("col", col_o, o.col);
      check_eq("valid", tap_valid_o, o.vld);
      check_eq("taps", taps_o, o.taps);
      if (o.tag == 1) begin
        check_eq("row5col3_taps", taps_o, 40'h13_23_33_43_53);
        check_eq("row5col3_valid", tap_valid_o, 5'b11111);
      end else if (o.tag == 2) begin
        check_eq("row1col0_taps", taps_o, 40'h00_00_00_00_10);
        check_eq("row1col0_valid", tap_valid_o, 5'b00011);
      end else if (o.tag == 3) begin
        check_eq("newline_col", col_o, 0);
        check_eq("newline_valid", tap_valid_o, 5'b00001);
      end
    end
    rst  = rs;
    y_i  = y;
    dv_i = dv;
    hs_i = hs;
    vs_i = vs;
    if (!rs) begin
      armed = 1;
      e = '{dv: 0, hs: 0, vs: 0, col: 0, taps: 0, vld: 0, tag: 0};
      q.delete();
      q.push_back(e);
      q.push_back(e);
      m_cnt = 0; m_sel = 0; m_seen = 0; m_width = 0;
      m_ovf = 0; m_dvp = 0; m_vsp = 0;
    end else begin
      addr  = (m_cnt >= MAXW) ? MAXW - 1 : m_cnt;
      e.dv  = dv;
      e.hs  = hs;
      e.vs  = vs;
      e.col = dv ? 11'(addr) : 11'd0;
      e.tag = tag;
      e.taps = '0;
      fill = '0;
      for (int k = 0; k < 5; k++) begin
        logic [7:0] raw;
        e.vld[k] = dv && (m_seen >= k);
        raw = (k == 0) ? y : m_mem[(m_sel - k + 4) % 4][addr];
        if (e.vld[k]) fill = raw;
`ifndef LB_BORDER_REPLICATE_EN
        else fill = '0;
`endif
        e.taps[k*8 +: 8] = fill;
      end
      q.push_back(e);
      if (dv) begin
        if (m_cnt < MAXW) begin
          m_mem[m_sel][m_cnt] = y;
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
      if (!dv && m_dvp) begin
        m_width = m_cnt;
        m_cnt   = 0;
        m_sel   = (m_sel + 1) % 4;
        if (m_seen < 4) m_seen++;
      end
      if (vs && !m_vsp) begin
        m_seen = 0;
        m_ovf  = 0;
      end
      m_dvp = dv;
      m_vsp = vs;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0);
  endtask

  task automatic vs_pulse();
    cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(2);
  endtask

  // One line of n pixels (y = base + col) followed by blanking with a hsync pulse
  task automatic line(input int n, input int base, input int tag_col, input int tag);
    for (int c = 0; c < n; c++)
      cycle(8'((base + c) & 8'hff), 1'b1, 1'b0, 1'b0, 1'b1, (c == tag_col) ? tag : 0);
    cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    cycle(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 0);
    idle(2);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    idle(2);

    // 8 x 16 frame, y = 16*row + col
    vs_pulse();
    for (int r = 0; r < 8; r++)
      line(16, 16 * r, (r == 5) ? 3 : ((r == 1) ? 0 : -1), (r == 5) ? 1 : ((r == 1) ? 2 : 0));

    // Alternating widths
    vs_pulse();
    line(10, 8'h80, -1, 0);
    check_eq("width_10a", width_o, 10);
    line(12, 8'h90, -1, 0);
    check_eq("width_12", width_o, 12);
    line(10, 8'ha0, -1, 0);
    check_eq("width_10b", width_o, 10);
    line(12, 8'hb0, -1, 0);

    // Frame start coincident with end of line
    line(8, 8'hc0, -1, 0);
    for (int c = 0; c < 8; c++) cycle(8'(8'hd0 + c), 1'b1, 1'b0, 1'b0, 1'b1, 0);
    cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(3);
    line(8, 8'he0, 0, 3);
    line(8, 8'hf0, -1, 0);

    // Overflowing line
    vs_pulse();
    line(1925, 0, -1, 0);
    check_eq("ovf_width", width_o, MAXW);
    check_eq("ovf_set", ovf_o, 1'b1);
    vs_pulse();
    check_eq("ovf_clear", ovf_o, 1'b0);

    // Reset in the middle of line 3
    line(8, 8'h10, -1, 0);
    line(8, 8'h20, -1, 0);
    line(8, 8'h30, -1, 0);
    for (int c = 0; c < 4; c++) cycle(8'(8'h40 + c), 1'b1, 1'b0, 1'b0, 1'b1, 0);
    cycle(8'h44, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    check_eq("rst_dv", dv_o, 1'b0);
    check_eq("rst_taps", taps_o, 40'h0);
    idle(2);
    line(8, 8'h50, 0, 3);
    line(8, 8'h60, -1, 0);
    idle(4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
